vga_rx_monitor: RTL and testbench

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_sync_edge.sv | 49 ++++
 rtl/vga_rx_monitor.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, monitor state encoding and small helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

    // 640x480@60 timing, counted in pixel clocks / lines
    localparam int VGA_HPIXELS = 800;
    localparam int VGA_HSYNC_W = 96;
    localparam int VGA_VLINES  = 521;
    localparam int VGA_VSYNC_W = 2;
    localparam int VGA_HBP     = 144;
    localparam int VGA_HFP     = 783;
    localparam int VGA_VBP     = 31;
    localparam int VGA_VFP     = 510;

    localparam int VGA_CNT_W = 10;
    localparam int VGA_LIT_W = 19;

    // Sentinel for "no lit pixel seen"; never a legal active-relative coordinate
    localparam logic [VGA_CNT_W-1:0] VGA_NO_PIXEL = 10'h3FF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } vga_state_e;

    // Saturating increment for the 10-bit position counters
    function automatic logic [VGA_CNT_W-1:0] sat_inc10(input logic [VGA_CNT_W-1:0] v);
        return (v == '1) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Edge detector and saturating low-run counter for one low-active sync line.
// Latency: edges are combinational from the current sample; run_o is the count before this sample.
// Backpressure: none; state advances only on enabled (pix_en) samples.
//
// Ports: clk, rst_n; en_i sample strobe; sync_i sync level; step_i counts one unit
//        while sync is low; fall_o/rise_o edge flags; run_o low-run length so far.
module vga_sync_edge #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             step_i,
    output logic             fall_o,
    output logic             rise_o,
    output logic [CNT_W-1:0] run_o
);

    logic             prev_q;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_d;

    assign fall_o = en_i &  prev_q & ~sync_i;
    assign rise_o = en_i & ~prev_q &  sync_i;
    assign run_o  = run_q;

    // The run restarts whenever the line is high, so on the rising sample
    // run_q still holds the full length of the pulse that just ended.
    always_comb begin
        run_d = run_q;
        if (sync_i) begin
            run_d = '0;
        end else if (step_i && (run_q != '1)) begin
            run_d = run_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            run_q  <= '0;
        end else if (en_i) begin
            prev_q <= sync_i;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: verifies sync timing, locks, and reports lit-pixel statistics per frame.
// Latency: checks and state update on the pix_en edge that samples the event; frame results one clk after the frame start.
// Backpressure: none; the source is free-running and every pix_en sample is consumed.
//
// Ports: clk, rst_n; pix_en pixel strobe; hsync/vsync low-active syncs; red/green/blue colour;
//        locked timing verified; frame_done 1-clk result strobe; lit_count lit active pixels;
//        first_x/first_y first lit pixel (3FF when none); err_flags sticky {frame,vsync,line,hsync}.
module vga_rx_monitor
    import vga_pkg::*;
#(
    parameter int HPIXELS   = VGA_HPIXELS,
    parameter int HSYNC_W   = VGA_HSYNC_W,
    parameter int VLINES    = VGA_VLINES,
    parameter int VSYNC_W   = VGA_VSYNC_W,
    parameter int HBP       = VGA_HBP,
    parameter int HFP       = VGA_HFP,
    parameter int VBP       = VGA_VBP,
    parameter int VFP       = VGA_VFP,
    parameter int COLOR_LAG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_en,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [3:0]           red,
    input  logic [3:0]           green,
    input  logic [3:0]           blue,
    output logic                 locked,
    output logic                 frame_done,
    output logic [VGA_LIT_W-1:0] lit_count,
    output logic [VGA_CNT_W-1:0] first_x,
    output logic [VGA_CNT_W-1:0] first_y,
    output logic [3:0]           err_flags
);

    localparam logic [VGA_CNT_W-1:0] H_LAST = VGA_CNT_W'(HPIXELS - 1);
    localparam logic [VGA_CNT_W-1:0] V_LAST = VGA_CNT_W'(VLINES - 1);
    localparam logic [VGA_CNT_W-1:0] HS_LEN = VGA_CNT_W'(HSYNC_W);
    localparam logic [VGA_CNT_W-1:0] VS_LEN = VGA_CNT_W'(VSYNC_W);
    // Window bounds expressed on the sample's own counter value, so the
    // colour lag never needs a signed subtraction.
    localparam logic [VGA_CNT_W-1:0] X_LO   = VGA_CNT_W'(HBP + COLOR_LAG);
    localparam logic [VGA_CNT_W-1:0] X_HI   = VGA_CNT_W'(HFP + COLOR_LAG);
    localparam logic [VGA_CNT_W-1:0] Y_LO   = VGA_CNT_W'(VBP);
    localparam logic [VGA_CNT_W-1:0] Y_HI   = VGA_CNT_W'(VFP);

    // ---------------- sync edges ----------------
    logic                 hs_fall, hs_rise, vs_fall, vs_rise;
    logic [VGA_CNT_W-1:0] hs_run, vs_run;
    logic                 line_start, frame_start;

    vga_sync_edge #(.CNT_W(VGA_CNT_W)) u_hs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (pix_en),
        .sync_i (hsync),
        .step_i (1'b1),
        .fall_o (hs_fall),
        .rise_o (hs_rise),
        .run_o  (hs_run)
    );

    // vsync low time is measured in lines, so it steps on line starts only
    vga_sync_edge #(.CNT_W(VGA_CNT_W)) u_vs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (pix_en),
        .sync_i (vsync),
        .step_i (line_start),
        .fall_o (vs_fall),
        .rise_o (vs_rise),
        .run_o  (vs_run)
    );

    assign line_start  = hs_fall;
    assign frame_start = hs_fall & vs_fall;

    // ---------------- position counters ----------------
    logic [VGA_CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            hc_d = line_start ? '0 : sat_inc10(hc_q);
            if (frame_start) begin
                vc_d = '0;
            end else if (line_start) begin
                vc_d = sat_inc10(vc_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // ---------------- timing checks (pre-update counters) ----------------
    vga_state_e state_q;
    logic [3:0] err_raw, err_det;
    logic       any_err;
    logic       frame_err_q;
    logic       report;

    assign err_raw[0] = hs_rise     && (hs_run != HS_LEN);
    assign err_raw[1] = line_start  && (hc_q   != H_LAST);
    assign err_raw[2] = vs_rise     && (vs_run != VS_LEN);
    assign err_raw[3] = frame_start && (vc_q   != V_LAST);
    assign err_det    = (state_q != ST_SEARCH) ? err_raw : 4'b0000;
    assign any_err    = |err_det;

    // Results of the just-ended frame are published only if it was checked
    // from its very start and nothing failed, including checks closing it now.
    assign report = frame_start && (state_q != ST_SEARCH) && !frame_err_q && !any_err;

    // ---------------- pixel accumulation ----------------
    logic                 lit_px;
    logic [VGA_LIT_W-1:0] acc_q, acc_d, acc_base;
    logic                 found_q, found_d, found_base;
    logic [VGA_CNT_W-1:0] fx_q, fx_d, fy_q, fy_d;
    logic                 frame_err_d;

    assign lit_px = pix_en && ((red | green | blue) != 4'd0)
                 && (hc_d >= X_LO) && (hc_d <= X_HI)
                 && (vc_d >= Y_LO) && (vc_d <= Y_HI);

    always_comb begin
        acc_base    = frame_start ? '0   : acc_q;
        found_base  = frame_start ? 1'b0 : found_q;
        acc_d       = acc_base;
        found_d     = found_base;
        fx_d        = fx_q;
        fy_d        = fy_q;
        frame_err_d = frame_start ? 1'b0 : (frame_err_q | any_err);
        if (lit_px) begin
            if (acc_base != '1) begin
                acc_d = acc_base + 19'd1;
            end
            if (!found_base) begin
                found_d = 1'b1;
                fx_d    = hc_d - X_LO;
                fy_d    = vc_d - Y_LO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            found_q     <= 1'b0;
            fx_q        <= VGA_NO_PIXEL;
            fy_q        <= VGA_NO_PIXEL;
            frame_err_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            found_q     <= found_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------- lock FSM with registered outputs ----------------
    logic                 locked_q, frame_done_q;
    logic [VGA_LIT_W-1:0] lit_count_q;
    logic [VGA_CNT_W-1:0] first_x_q, first_y_q;
    logic [3:0]           err_flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SEARCH;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            lit_count_q  <= '0;
            first_x_q    <= VGA_NO_PIXEL;
            first_y_q    <= VGA_NO_PIXEL;
            err_flags_q  <= 4'b0000;
        end else begin
            frame_done_q <= report;
            err_flags_q  <= err_flags_q | err_det;
            if (report) begin
                lit_count_q <= acc_q;
                first_x_q   <= found_q ? fx_q : VGA_NO_PIXEL;
                first_y_q   <= found_q ? fy_q : VGA_NO_PIXEL;
            end
            case (state_q)
                ST_SEARCH: begin
                    if (frame_start) begin
                        state_q <= ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (report) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (any_err) begin
                        state_q  <= ST_ACQUIRE;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign lit_count  = lit_count_q;
    assign first_x    = first_x_q;
    assign first_y    = first_y_q;
    assign err_flags  = err_flags_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Frame-level bench: a behavioural VGA source draws images, a simple image model predicts the reports.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_rx_monitor;

    // Scaled-down timing keeps each frame at 1200 pixels
    localparam int HP  = 40;
    localparam int HS  = 6;
    localparam int VL  = 30;
    localparam int VS  = 2;
    localparam int HBP = 10;
    localparam int HFP = 37;
    localparam int VBP = 4;
    localparam int VFP = 27;
    localparam int LAG = 1;
    localparam int AW  = HFP - HBP + 1;
    localparam int AH  = VFP - VBP + 1;
    localparam int NV  = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [3:0]  red = 4'd0, green = 4'd0, blue = 4'd0;
    logic        locked, frame_done;
    logic [18:0] lit_count;
    logic [9:0]  first_x, first_y;
    logic [3:0]  err_flags;

    vga_rx_monitor #(
        .HPIXELS(HP), .HSYNC_W(HS), .VLINES(VL), .VSYNC_W(VS),
        .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP), .COLOR_LAG(LAG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .locked(locked), .frame_done(frame_done), .lit_count(lit_count),
        .first_x(first_x), .first_y(first_y), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    bit img [0:AH-1][0:AW-1];

    typedef struct {
        int hs_w; int short_ln; int vs_w; int nlines;
        int bx; int by; int bw; int bh; bit rnd;
        bit exp_done; int exp_lit; int exp_fx; int exp_fy;
        bit exp_lock; logic [3:0] exp_err;
    } vec_t;

    vec_t tab [0:NV-1];

    function automatic vec_t mk(int hs_w, int short_ln, int vs_w, int nlines,
                                int bx, int by, int bw, int bh, bit rnd,
                                bit dn, int lit, int fx, int fy, bit lk, logic [3:0] err);
        vec_t r;
        r.hs_w = hs_w; r.short_ln = short_ln; r.vs_w = vs_w; r.nlines = nlines;
        r.bx = bx; r.by = by; r.bw = bw; r.bh = bh; r.rnd = rnd;
        r.exp_done = dn; r.exp_lit = lit; r.exp_fx = fx; r.exp_fy = fy;
        r.exp_lock = lk; r.exp_err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic pe, input logic hs, input logic vs, input logic [11:0] rgb);
        @(negedge clk);
        pix_en = pe; hsync = hs; vsync = vs;
        {red, green, blue} = rgb;
    endtask

    // Occasional idle clocks carry junk that must be ignored
    task automatic send_pixel(input logic hs, input logic vs, input logic [11:0] rgb);
        if ($urandom_range(0, 3) == 0)
            tick(1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
        tick(1'b1, hs, vs, rgb);
    endtask

    task automatic idle();
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic draw(input vec_t r);
        for (int y = 0; y < AH; y++)
            for (int x = 0; x < AW; x++)
                img[y][x] = r.rnd ? ($urandom_range(0, 15) == 0)
                                  : (x >= r.bx && x < r.bx + r.bw && y >= r.by && y < r.by + r.bh);
    endtask

    task automatic model(output int lit, output int fx, output int fy);
        lit = 0; fx = 1023; fy = 1023;
        for (int y = 0; y < AH; y++)
            for (int x = 0; x < AW; x++)
                if (img[y][x]) begin
                    if (lit == 0) begin fx = x; fy = y; end
                    lit++;
                end
    endtask

    // Source: sync for position h, colour for pixel h-LAG
    task automatic send_frame(input vec_t r, input int l0, input int l1);
        for (int v = l0; v < l1; v++) begin
            int len;
            int hw;
            len = (v == r.short_ln) ? HP - 1 : HP;
            hw  = (v == 5) ? r.hs_w : HS;
            for (int h = 0; h < len; h++) begin
                int ax, ay;
                logic [11:0] rgb;
                ax = h - LAG - HBP;
                ay = v - VBP;
                if (ax >= 0 && ax < AW && ay >= 0 && ay < AH)
                    rgb = img[ay][ax] ? 12'($urandom_range(1, 4095)) : 12'd0;
                else
                    rgb = 12'($urandom);
                if (r.short_ln >= 0 && v == r.short_ln + 1 && h == 0)
                    check("locked_before_short_line", {31'd0, locked}, 32'd1);
                send_pixel((h < hw) ? 1'b0 : 1'b1, (v < r.vs_w) ? 1'b0 : 1'b1, rgb);
                if (r.short_ln >= 0 && v == r.short_ln + 1 && h == 1) begin
                    check("locked_after_short_line", {31'd0, locked}, 32'd0);
                    check("line_err_flag", {31'd0, err_flags[1]}, 32'd1);
                end
            end
        end
        idle();
    endtask

    task automatic check_outputs(input string tag, input int lk, input int dn,
                                 input int lit, input int fx, input int fy, input int err);
        check({tag, "_locked"},     {31'd0, locked},     lk);
        check({tag, "_frame_done"}, {31'd0, frame_done}, dn);
        check({tag, "_lit"},        {13'd0, lit_count},  lit);
        check({tag, "_first_x"},    {22'd0, first_x},    fx);
        check({tag, "_first_y"},    {22'd0, first_y},    fy);
        check({tag, "_err"},        {28'd0, err_flags},  err);
    endtask

    initial begin
        vec_t clean;
        vec_t fa;
        int d0;

        clean = mk(HS, -1, VS, VL, 0, 0, 0, 0, 0, 1, 0, 1023, 1023, 1, 4'h0);
        //             hs_w sl  vs  nl  bx  by bw bh rnd  dn lit   fx    fy  lk err
        tab[0]  = mk(HS, -1, VS, VL,  0,  0, 0, 0, 0,  1,  0, 1023, 1023, 0, 4'h0);
        tab[1]  = mk(HS, -1, VS, VL,  0,  0, 0, 0, 0,  1,  0, 1023, 1023, 1, 4'h0);
        tab[2]  = mk(HS, -1, VS, VL,  7,  3, 5, 4, 0,  1, 20,    7,    3, 1, 4'h0);
        tab[3]  = mk(HS, 10, VS, VL,  0,  0, 0, 0, 0,  0, 20,    7,    3, 0, 4'h2);
        tab[4]  = mk(HS, -1, VS, VL,  0,  0, 2, 2, 0,  1,  4,    0,    0, 0, 4'h2);
        tab[5]  = mk(HS-1,-1,VS, VL, 27, 23, 1, 1, 0,  0,  4,    0,    0, 0, 4'h3);
        tab[6]  = mk(HS, -1, VS, VL, 27, 23, 1, 1, 0,  1,  1,   27,   23, 0, 4'h3);
        tab[7]  = mk(HS, -1, 3,  VL,  0,  0, 0, 0, 0,  0,  1,   27,   23, 0, 4'h7);
        tab[8]  = mk(HS, -1, VS, VL,  0,  0, 0, 0, 0,  1,  0, 1023, 1023, 0, 4'h7);
        tab[9]  = mk(HS, -1, VS, VL-1,0,  0, 0, 0, 0,  0,  0, 1023, 1023, 1, 4'h7);
        tab[10] = mk(HS, -1, VS, VL,  0,  0, 0, 0, 0,  1,  0, 1023, 1023, 0, 4'hF);
        for (int i = 11; i < NV; i++)
            tab[i] = mk(HS, -1, VS, VL, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 4'hF);

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs("reset", 0, 0, 0, 1023, 1023, 0);
        rst_n = 1'b1;

        for (int i = 0; i <= NV; i++) begin
            vec_t r;
            r = (i < NV) ? tab[i] : clean;
            draw(r);
            if (i < NV && r.rnd) begin
                int lit, fx, fy;
                model(lit, fx, fy);
                tab[i].exp_lit = lit; tab[i].exp_fx = fx; tab[i].exp_fy = fy;
            end
            d0 = done_cnt;
            send_frame(r, 0, r.nlines);
            if (i < NV) begin
                check($sformatf("f%0d_locked", i), {31'd0, locked}, {31'd0, tab[i].exp_lock});
                check($sformatf("f%0d_err", i), {28'd0, err_flags}, {28'd0, tab[i].exp_err});
            end
            if (i == 0)
                check("f0_no_report", done_cnt - d0, 0);
            else begin
                check($sformatf("f%0d_done", i-1), done_cnt - d0, {31'd0, tab[i-1].exp_done});
                check($sformatf("f%0d_lit", i-1), {13'd0, lit_count}, tab[i-1].exp_lit);
                check($sformatf("f%0d_fx", i-1), {22'd0, first_x}, tab[i-1].exp_fx);
                check($sformatf("f%0d_fy", i-1), {22'd0, first_y}, tab[i-1].exp_fy);
            end
        end

        // Reset in the middle of a frame, asynchronously between edges
        draw(clean);
        send_frame(clean, 0, 15);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_outputs("midreset", 0, 0, 0, 1023, 1023, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        send_frame(clean, 15, VL);
        fa = mk(HS, -1, VS, VL, 20, 10, 3, 2, 0, 0, 0, 0, 0, 0, 4'h0);
        draw(fa);
        send_frame(fa, 0, VL);
        check("post_reset_frame1_done", done_cnt - d0, 0);
        check("post_reset_frame1_locked", {31'd0, locked}, 0);
        draw(clean);
        send_frame(clean, 0, VL);
        check_outputs("post_reset_frame2", 1, 0, 6, 20, 10, 0);
        check("post_reset_frame2_done", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
